// File: rtl/tmds_pattern_gen.sv
// Multi-channel TMDS scope pattern generator: square-wave clock, control symbols and PRBS7.
// Optional feature macro: TMDS_PATTERN_PRBS_EN (PRBS7 LFSR plus per-channel delay line).
module tmds_pattern_gen #(
    parameter int CHANNELS  = 3,
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [1:0]           mode_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic [CHANNELS-1:0]  tmds_p_o,
    output logic [CHANNELS-1:0]  tmds_n_o,
    output logic                 bit_strobe_o,
    output logic                 frame_o
);

    typedef enum logic [1:0] {
        MODE_CLK    = 2'd0,
        MODE_CTRL   = 2'd1,
        MODE_PRBS   = 2'd2,
        MODE_STATIC = 2'd3
    } mode_e;

    localparam logic [9:0]       CLK_SYM   = 10'b0000011111;
    // Element [k] is the control symbol for channels with c mod 4 == k; bit 0 goes out first.
    localparam logic [3:0][9:0]  CTRL_SYMS = {10'b1010101011, 10'b0101010100,
                                              10'b0010101011, 10'b1101010100};

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]           idx_q, idx_d;
    mode_e                mode_q, mode_d;
    logic                 en_q, en_d;
    logic [CHANNELS-1:0]  p_q, p_d;
    logic [CHANNELS-1:0]  n_q;
    logic                 strobe_q;
    logic                 frame_q;
    logic                 new_bit;
    logic                 wrap;

    assign new_bit = (cnt_q == '0);
    assign wrap    = new_bit && (idx_q == 4'd9);
    assign cnt_d   = new_bit ? div_i : cnt_q - DIV_WIDTH'(1);
    assign idx_d   = !new_bit ? idx_q : (wrap ? 4'd0 : idx_q + 4'd1);
    assign mode_d  = wrap ? mode_e'(mode_i) : mode_q;
    assign en_d    = wrap ? enable_i : en_q;

`ifdef TMDS_PATTERN_PRBS_EN
    localparam int DLY_W = (CHANNELS > 1) ? CHANNELS - 1 : 1;

    logic [6:0]          lfsr_q, lfsr_d, lfsr_eff;
    logic [DLY_W-1:0]    dly_q, dly_d, dly_eff;
    logic [CHANNELS-1:0] prbs_bits;
    logic                prbs_reload;
    logic                prbs_adv;

    // Entering mode 2 restarts the sequence on the very first bit of the new symbol.
    assign prbs_reload = wrap && (mode_d == MODE_PRBS) && (mode_q != MODE_PRBS);
    assign prbs_adv    = new_bit && (mode_d == MODE_PRBS);
    assign lfsr_eff    = prbs_reload ? 7'h7F : lfsr_q;
    assign dly_eff     = prbs_reload ? '1 : dly_q;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        prbs_bits    = '0;
        prbs_bits[0] = lfsr_eff[6];
        for (int c = 1; c < CHANNELS; c++) prbs_bits[c] = dly_eff[c-1];
        lfsr_d = lfsr_q;
        dly_d  = dly_q;
        if (prbs_adv) begin
            lfsr_d   = {lfsr_eff[5:0], lfsr_eff[6] ^ lfsr_eff[5]};
            dly_d[0] = lfsr_eff[6];
            for (int i = 1; i < DLY_W; i++) dly_d[i] = dly_eff[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= 7'h7F;
            dly_q  <= '1;
        end else begin
            lfsr_q <= lfsr_d;
            dly_q  <= dly_d;
        end
    end
`endif

    always_comb begin
        p_d = p_q;
        if (new_bit) begin
            for (int c = 0; c < CHANNELS; c++) begin
                unique case (mode_d)
                    MODE_CLK:  p_d[c] = CLK_SYM[idx_d];
                    MODE_CTRL: p_d[c] = CTRL_SYMS[c[1:0]][idx_d];
`ifdef TMDS_PATTERN_PRBS_EN
                    MODE_PRBS: p_d[c] = prbs_bits[c];
`else
                    MODE_PRBS: p_d[c] = CLK_SYM[idx_d];
`endif
                    default:   p_d[c] = 1'b0;
                endcase
            end
            if (!en_d) p_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            idx_q    <= 4'd9;
            mode_q   <= MODE_STATIC;
            en_q     <= 1'b0;
            p_q      <= '0;
            n_q      <= '1;
            strobe_q <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            mode_q   <= mode_d;
            en_q     <= en_d;
            p_q      <= p_d;
            n_q      <= ~p_d;
            strobe_q <= new_bit;
            frame_q  <= wrap;
        end
    end

    assign tmds_p_o     = p_q;
    assign tmds_n_o     = n_q;
    assign bit_strobe_o = strobe_q;
    assign frame_o      = frame_q;

endmodule

// File: tb/tb_tmds_pattern_gen.sv
// Directed bench for tmds_pattern_gen (CHANNELS=3); expectations follow TMDS_PATTERN_PRBS_EN when defined.
module tb_tmds_pattern_gen;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [1:0] mode;
    logic [7:0] div;
    logic [2:0] tmds_p;
    logic [2:0] tmds_n;
    logic       bit_strobe;
    logic       frame;

    int checks = 0;
    int errors = 0;

    logic [6:0] m_lfsr;
    logic [1:0] m_hist;

    int ch0_seq[10] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 1};
    int ch1_seq[10] = '{1, 1, 0, 1, 0, 1, 0, 1, 0, 0};
    int ch2_seq[10] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0};

    tmds_pattern_gen #(.CHANNELS(3), .DIV_WIDTH(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .mode_i       (mode),
        .div_i        (div),
        .tmds_p_o     (tmds_p),
        .tmds_n_o     (tmds_n),
        .bit_strobe_o (bit_strobe),
        .frame_o      (frame)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [2:0] clk_exp(input int idx);
        return (idx < 5) ? 3'b111 : 3'b000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the sample point of cycle 0 (first edge after release).
    task automatic apply_reset(input logic [1:0] m, input logic e, input logic [7:0] d);
        rst = 1'b1; mode = m; enable = e; div = d;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic model_reset();
        m_lfsr = 7'h7F;
        m_hist = 2'b11;
    endtask

    task automatic model_step(input int idx, output logic [2:0] exp);
`ifdef TMDS_PATTERN_PRBS_EN
        logic b0;
        b0     = m_lfsr[6];
        exp    = {m_hist[1], m_hist[0], b0};
        m_hist = {m_hist[0], b0};
        m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
`else
        exp = clk_exp(idx);
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 2'd0; enable = 1'b1; div = 8'd3;
        #2;
        for (int pass = 0; pass < 2; pass++) begin
            checks++;
            if (tmds_p !== 3'b000) begin errors++; $display("FAIL reset_p pass%0d got %b want 000", pass, tmds_p); end
            checks++;
            if (tmds_n !== 3'b111) begin errors++; $display("FAIL reset_n pass%0d got %b want 111", pass, tmds_n); end
            checks++;
            if (bit_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe pass%0d got %b want 0", pass, bit_strobe); end
            checks++;
            if (frame !== 1'b0) begin errors++; $display("FAIL reset_frame pass%0d got %b want 0", pass, frame); end
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_clock_mode();
        logic [7:0] got, exp;
        apply_reset(2'd0, 1'b1, 8'd3);
        for (int k = 0; k < 80; k++) begin
            exp = {((k % 40) < 20) ? 3'b111 : 3'b000, ((k % 40) < 20) ? 3'b000 : 3'b111,
                   (k % 4) == 0, (k % 40) == 0};
            got = {tmds_p, tmds_n, bit_strobe, frame};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL clock_mode cyc%0d got p/n/strb/frm=%b want %b", k, got, exp);
            end
            step();
        end
    endtask

    task automatic test_control();
        logic [7:0] got, exp;
        logic [2:0] ep;
        int idx;
        apply_reset(2'd1, 1'b1, 8'd0);
        for (int k = 0; k < 20; k++) begin
            idx = k % 10;
            ep  = {ch2_seq[idx] != 0, ch1_seq[idx] != 0, ch0_seq[idx] != 0};
            exp = {ep, ~ep, 1'b1, idx == 0};
            got = {tmds_p, tmds_n, bit_strobe, frame};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL control cyc%0d got p/n/strb/frm=%b want %b", k, got, exp);
            end
            step();
        end
    endtask

    task automatic test_prbs();
        logic [5:0] got, exp;
        logic [2:0] ep;
        logic [7:0] first8;
        apply_reset(2'd0, 1'b1, 8'd0);
        mode   = 2'd2;
        first8 = '0;
        for (int k = 1; k < 150; k++) begin
            step();
            if (k < 10) ep = clk_exp(k);
            else begin
                if (k == 10) model_reset();
                model_step(k % 10, ep);
            end
            if (k >= 10 && k < 18) first8 = {first8[6:0], tmds_p[0]};
            exp = {ep, ~ep};
            got = {tmds_p, tmds_n};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL prbs cyc%0d got p/n=%b want %b", k, got, exp);
            end
        end
        checks++;
`ifdef TMDS_PATTERN_PRBS_EN
        if (first8 !== 8'b11111110) begin
            errors++; $display("FAIL prbs_first8 got %b want 11111110", first8);
        end
`else
        if (first8 !== 8'b11111000) begin
            errors++; $display("FAIL prbs_first8 got %b want 11111000", first8);
        end
`endif
    endtask

    task automatic test_mode_enable_change();
        logic [7:0] got, exp;
        logic [2:0] ep;
        apply_reset(2'd0, 1'b1, 8'd0);
        for (int k = 0; k < 40; k++) begin
            if (k < 10 || (k >= 20 && k < 30)) ep = clk_exp(k % 10);
            else ep = 3'b000;
            exp = {ep, ~ep, 1'b1, (k % 10) == 0};
            got = {tmds_p, tmds_n, bit_strobe, frame};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL mode_enable_change cyc%0d got p/n/strb/frm=%b want %b", k, got, exp);
            end
            if (k == 4)  mode = 2'd3;
            if (k == 19) mode = 2'd0;
            if (k == 21) enable = 1'b0;
            step();
        end
        enable = 1'b1;
    endtask

    task automatic test_div_change();
        logic exp;
        apply_reset(2'd0, 1'b1, 8'd3);
        for (int k = 0; k < 16; k++) begin
            exp = (k == 0) || (k >= 4 && (k % 2) == 0);
            checks++;
            if (bit_strobe !== exp) begin
                errors++;
                $display("FAIL div_change cyc%0d got strobe=%b want %b", k, bit_strobe, exp);
            end
            if (k == 1) div = 8'd1;
            step();
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got, exp;
        logic [2:0] ep;
        apply_reset(2'd2, 1'b1, 8'd0);
        repeat (5) step();
        #2;
        rst = 1'b1;
        #1;
        got = {tmds_p, tmds_n, bit_strobe, frame};
        checks++;
        if (got !== 8'b000_111_0_0) begin
            errors++; $display("FAIL reset_mid_async got p/n/strb/frm=%b want 00011100", got);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        model_reset();
        for (int k = 0; k < 140; k++) begin
            model_step(k % 10, ep);
            exp = {ep, ~ep, 1'b1, (k % 10) == 0};
            got = {tmds_p, tmds_n, bit_strobe, frame};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_mid_restart cyc%0d got p/n/strb/frm=%b want %b", k, got, exp);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_clock_mode();
        test_control();
        test_prbs();
        test_mode_enable_change();
        test_div_change();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
